// File: rtl/video_pkg.sv
// Shared video timing constants and colour helpers.
package video_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_H_POL    = 1'b0;
    localparam bit VGA640_V_POL    = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_H_POL    = 1'b1;
    localparam bit SVGA800_V_POL    = 1'b1;

    // Control word carried through the alignment delay line (pin levels).
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } ctrl_t;

    // Counter width for a total count; never narrower than one bit.
    function automatic int ctr_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    // Replicate the low 'bits' bits of v MSB-first across 8 bits.
    function automatic logic [7:0] expand8(input logic [7:0] v, input int bits);
        logic [7:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            o[7-i] = v[3'(bits - 1 - (i % bits))];
        end
        return o;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel request / video output bundle of the timing generator.
interface video_timing_gen_if #(
    parameter int IN_BITS = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
);
    logic [IN_BITS-1:0] in_r;
    logic [IN_BITS-1:0] in_g;
    logic [IN_BITS-1:0] in_b;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               req;
    logic               line_start;
    logic               frame_start;
    logic               hsync;
    logic               vsync;
    logic               blank;
    logic               de;
    logic [7:0]         r8;
    logic [7:0]         g8;
    logic [7:0]         b8;

    modport master (
        input  in_r, in_g, in_b,
        output x, y, req, line_start, frame_start,
        output hsync, vsync, blank, de, r8, g8, b8
    );

    modport slave (
        output in_r, in_g, in_b,
        input  x, y, req, line_start, frame_start,
        input  hsync, vsync, blank, de, r8, g8, b8
    );
endinterface

// File: rtl/video_delay.sv
// Width-by-depth shift register with a reset value; q_pre is the word that
// will appear on q after the next edge.
module video_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_pre
);
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock; reset flushes every stage to the idle word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_pre_in
            assign q_pre = d;
        end else begin : g_pre_stage
            assign q_pre = stage[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters, pixel requests, sync/blank generation
// delayed to meet the pixel source latency, and colour expansion to 8 bits.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int IN_BITS  = 4,
    parameter int PIPE     = 1
) (
    input  logic              clk_pixel,
    input  logic              reset,
    video_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = ctr_width(H_TOTAL);
    localparam int Y_W     = ctr_width(V_TOTAL);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam ctrl_t CTRL_IDLE = '{hsync: ~H_POL, vsync: ~V_POL, blank: 1'b1};

    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           active;
    logic           hs_act;
    logic           vs_act;
    ctrl_t          ctrl_raw;
    ctrl_t          ctrl_out;
    ctrl_t          ctrl_pre;
    logic [7:0]     r8_q;
    logic [7:0]     g8_q;
    logic [7:0]     b8_q;

    // Raster counters: x wraps every line, y advances on the x wrap.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
            x_cnt <= x_cnt + 1'b1;
        end
    end

    // Raw region decode for the coordinate currently presented.
    always_comb begin
        active         = (int'(x_cnt) < H_ACTIVE) && (int'(y_cnt) < V_ACTIVE);
        hs_act         = (int'(x_cnt) >= HS_START) && (int'(x_cnt) < HS_END);
        vs_act         = (int'(y_cnt) >= VS_START) && (int'(y_cnt) < VS_END);
        ctrl_raw.hsync = hs_act ? H_POL : ~H_POL;
        ctrl_raw.vsync = vs_act ? V_POL : ~V_POL;
        ctrl_raw.blank = ~active;
    end

    // PIPE+1 stages: PIPE for the pixel source, one for the colour register.
    video_delay #(
        .WIDTH   ($bits(ctrl_t)),
        .DEPTH   (PIPE + 1),
        .RST_VAL (CTRL_IDLE)
    ) u_delay (
        .clk   (clk_pixel),
        .reset (reset),
        .d     (ctrl_raw),
        .q     (ctrl_out),
        .q_pre (ctrl_pre)
    );

    // Colour register, qualified by the blank that will accompany it on the outputs.
    always_ff @(posedge clk_pixel) begin
        if (reset || ctrl_pre.blank) begin
            r8_q <= '0;
            g8_q <= '0;
            b8_q <= '0;
        end else begin
            r8_q <= expand8(8'(vid.in_r), IN_BITS);
            g8_q <= expand8(8'(vid.in_g), IN_BITS);
            b8_q <= expand8(8'(vid.in_b), IN_BITS);
        end
    end

    assign vid.x           = x_cnt;
    assign vid.y           = y_cnt;
    assign vid.req         = active;
    assign vid.line_start  = (x_cnt == '0);
    assign vid.frame_start = (x_cnt == '0) && (y_cnt == '0);
    assign vid.hsync       = ctrl_out.hsync;
    assign vid.vsync       = ctrl_out.vsync;
    assign vid.blank       = ctrl_out.blank;
    assign vid.de          = ~ctrl_out.blank;
    assign vid.r8          = r8_q;
    assign vid.g8          = g8_q;
    assign vid.b8          = b8_q;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameter V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical front porch, sync and back porch in lines.
REQ-005 Parameter H_POL, V_POL, default 0: sync active level; 0 means active-low.
REQ-006 Parameter IN_BITS, default 4, legal 1..8: input colour bits per channel.
REQ-007 Parameter PIPE, default 1, legal 0..4: pixel-source latency in cycles.
REQ-008 Port clk_pixel, input, 1: the single clock; all logic is rising-edge.
REQ-009 Port reset, input, 1: synchronous, active-high reset.
REQ-010 Port in_r, in_g, in_b, input, IN_BITS each: pixel colour for the coordinate requested PIPE cycles earlier.
REQ-011 Port x, y, output, clog2(H_TOTAL) and clog2(V_TOTAL): current horizontal and vertical counters.
REQ-012 Port req, output, 1: high when (x,y) is in the active area.
REQ-013 Port line_start and frame_start, output, 1 each: one-cycle pulses on x==0, and on x==0 with y==0.
REQ-014 Port hsync, vsync, blank, de, output, 1 each: aligned video control; de equals not blank.
REQ-015 Port r8, g8, b8, output, 8 each: expanded colour, aligned with de.

Function
REQ-016 H_TOTAL and V_TOTAL shall be the sums of the horizontal and vertical parameters.
REQ-017 x shall count 0..H_TOTAL-1 and wrap to 0.
REQ-018 y shall increment only on the cycle x wraps, and shall wrap to 0 after V_TOTAL-1.
REQ-019 req shall be high iff x<H_ACTIVE and y<V_ACTIVE.
REQ-020 Raw hsync shall be active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
REQ-021 Raw vsync shall be active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-022 hsync, vsync, blank and de shall equal the raw values for a given (x,y) exactly PIPE+1 cycles after that (x,y) appears.
REQ-023 in_r, in_g and in_b shall be sampled PIPE cycles after the request.
REQ-024 r8, g8 and b8 shall be registered and appear in the same cycle as the matching de.
REQ-025 Expansion shall replicate the input MSB-first, then truncate to 8 bits; example: IN_BITS=4, 0xA gives 0xAA.
REQ-026 Example: IN_BITS=3, 3'b101 gives 8'b10110110.
REQ-027 r8, g8 and b8 shall be 0 whenever the aligned de is 0, whatever the inputs.
REQ-028 The output cadence shall not depend on the input values, so the block needs no backpressure and no handshake.
REQ-029 Counter widths shall be sized from the totals; no counter state shall exceed its total-1.

Reset
REQ-030 While reset is high, x, y and all delay stages shall load their reset values on each clock edge.
REQ-031 Reset values: x=0, y=0, hsync=~H_POL, vsync=~V_POL, blank=1, de=0, r8=g8=b8=0.
REQ-032 Reset values of the delay stages shall be inactive sync levels and blank.
REQ-033 The first cycle after reset deasserts shall present x=0, y=0, with req=1, line_start=1 and frame_start=1.
REQ-034 A reset asserted mid-frame shall abort the frame; output timing shall restart per REQ-033 with no partial pulse leaking out of the delay line.

Structure
REQ-035 Shared package video_pkg shall hold the standard timing constants: 640x480@60 and 800x600@60.
REQ-036 video_pkg shall also hold the expand8 colour-replication function.
REQ-037 One sub-module, video_delay (a parametrised width-by-depth shift register with reset value), shall implement the PIPE+1 alignment.

Verification
Bench parameters: H=8/2/3/1 (H_TOTAL 14), V=4/1/2/1 (V_TOTAL 8), PIPE=1, IN_BITS=4, polarity active-low.
REQ-038 Release reset, run 112 cycles -> frame_start exactly at cycles 0 and 112; line_start every 14 cycles; y wraps 7->0 at cycle 112.
REQ-039 Monitor hsync -> low for 3 cycles per line, beginning 2 cycles after (x=10) is presented; de high 8 cycles per active line, beginning at cycle 2.
REQ-040 Monitor vsync -> low spanning lines 5-6 (28 cycles), delayed 2 cycles relative to the counters.
REQ-041 Drive in_r = x[3:0] one cycle after each request -> r8 sequence 00,11,22..77 while de is high; r8=0 throughout blanking even with in_r=0xF.
REQ-042 Assert reset for 1 cycle at x=5, y=2 -> next cycle x=0, y=0, frame_start=1; hsync and vsync inactive and de=0 for 2 cycles, then normal timing.
REQ-043 Rerun with PIPE=0 and PIPE=4, and with IN_BITS=3 -> de lag of 1 and 5 cycles respectively; 3'b101 -> 0xB6.
